// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LOAD_WAIT,
        HZ_MD_BUSY,
        HZ_FLUSH2
    } hz_state_e;

    // Larger of two latencies; sizes the shared stall down-counter.
    function automatic int unsigned lat_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Decode-side hazard inputs and pipeline-register control outputs.
interface hazard_control_unit_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter int unsigned CNT_W      = 32
);
    logic                  mem_read_ex;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  rs1_used_id;
    logic                  rs2_used_id;
    logic                  muldiv_start_ex;
    logic                  pc_src;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_bubble;
    logic                  ex_hold;
    logic                  if_id_flush;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    // Pipeline side: presents decode state, consumes controls.
    modport master (
        output mem_read_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
               muldiv_start_ex, pc_src,
        input  pc_stall, if_id_stall, id_ex_bubble, ex_hold, if_id_flush,
               stall_cnt, flush_cnt
    );

    // Hazard unit side.
    modport slave (
        input  mem_read_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
               muldiv_start_ex, pc_src,
        output pc_stall, if_id_stall, id_ex_bubble, ex_hold, if_id_flush,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count on inc, hold once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / mul-div stall and branch-flush sequencer for the 5-stage core.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned MULDIV_LAT  = 4,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  hz
);

    localparam int unsigned CW = $clog2(lat_max(LOAD_LAT, MULDIV_LAT) + 1);

    hz_state_e       state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            match_c;
    logic            pc_stall_c, if_id_stall_c, id_ex_bubble_c, ex_hold_c, if_id_flush_c;
    logic            flush_inc_c;

    // Load-use match between EX load destination and ID sources.
    assign match_c = hz.mem_read_ex && (hz.rd_ex != '0) &&
                     ((hz.rs1_used_id && (hz.rd_ex == hz.rs1_id)) ||
                      (hz.rs2_used_id && (hz.rd_ex == hz.rs2_id)));

    // State and stall down-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state and zero-latency controls; all forced low while in reset.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_hold_c      = 1'b0;
        if_id_flush_c  = 1'b0;
        flush_inc_c    = 1'b0;
        if (rst_n) begin
            unique case (state)
                HZ_RUN: begin
                    if (hz.pc_src) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        flush_inc_c    = 1'b1;
                        if (FLUSH_DEPTH == 2) state_next = HZ_FLUSH2;
                    end else if (hz.muldiv_start_ex && (MULDIV_LAT > 1)) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        ex_hold_c     = 1'b1;
                        cnt_next      = CW'(MULDIV_LAT - 2);
                        state_next    = HZ_MD_BUSY;
                    end else if (match_c) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            cnt_next   = CW'(LOAD_LAT - 2);
                            state_next = HZ_LOAD_WAIT;
                        end
                    end
                end
                HZ_LOAD_WAIT: begin
                    if (hz.pc_src) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        flush_inc_c    = 1'b1;
                        cnt_next       = '0;
                        state_next     = (FLUSH_DEPTH == 2) ? HZ_FLUSH2 : HZ_RUN;
                    end else begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        if (cnt == '0) state_next = HZ_RUN;
                        else           cnt_next   = cnt - CW'(1);
                    end
                end
                HZ_MD_BUSY: begin
                    if (cnt != '0) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        ex_hold_c     = 1'b1;
                        cnt_next      = cnt - CW'(1);
                    end else begin
                        state_next = HZ_RUN;
                    end
                end
                HZ_FLUSH2: begin
                    if_id_flush_c = 1'b1;
                    state_next    = HZ_RUN;
                end
                default: state_next = HZ_RUN;
            endcase
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.id_ex_bubble = id_ex_bubble_c;
    assign hz.ex_hold      = ex_hold_c;
    assign hz.if_id_flush  = if_id_flush_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_stall_c),
        .q     (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_c),
        .q     (hz.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two differently configured units share one random stimulus stream.
module tb_hazard_control_unit;

    typedef struct packed {
        logic [4:0]  ctl;   // {pc_stall, if_id_stall, id_ex_bubble, ex_hold, if_id_flush}
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  ifa ();
    hazard_control_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) ifb ();

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .MULDIV_LAT(4), .FLUSH_DEPTH(2), .CNT_W(4))
        dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .MULDIV_LAT(2), .FLUSH_DEPTH(1), .CNT_W(32))
        dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

    // Configuration of each unit, as seen by the reference model.
    int unsigned c_ld [2] = '{3, 1};
    int unsigned c_md [2] = '{4, 2};
    int unsigned c_fd [2] = '{2, 1};
    longint      c_max[2] = '{64'd15, 64'hFFFF_FFFF};

    // Model state: cycles left in each pending action, and event totals.
    int     md_left[2], ld_left[2], fl_left[2];
    longint scnt[2], fcnt[2];

    exp_t sb[2][$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    task automatic model_step(input int d, input bit rst, input bit mem, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input bit u1,
                              input bit u2, input bit md, input bit pc);
        exp_t e;
        bit hit, stall, hold, bub, fl, redir;
        stall = 0; hold = 0; bub = 0; fl = 0; redir = 0;
        if (!rst) begin
            md_left[d] = 0; ld_left[d] = 0; fl_left[d] = 0;
            scnt[d] = 0; fcnt[d] = 0;
            sb[d].push_back('0);
            return;
        end
        e.sc = 32'(scnt[d]);
        e.fc = 32'(fcnt[d]);
        hit = mem && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        if (fl_left[d] > 0) begin
            fl = 1; fl_left[d] = 0;
        end else if (md_left[d] > 0) begin
            hold = (md_left[d] > 1); md_left[d]--;
        end else if (ld_left[d] > 0) begin
            if (pc) begin redir = 1; ld_left[d] = 0; end
            else    begin stall = 1; ld_left[d]--; end
        end else if (pc) begin
            redir = 1;
        end else if (md && c_md[d] > 1) begin
            hold = 1; md_left[d] = int'(c_md[d]) - 1;
        end else if (hit) begin
            stall = 1; ld_left[d] = int'(c_ld[d]) - 1;
        end
        if (redir) begin
            fl = 1; bub = 1;
            if (fcnt[d] < c_max[d]) fcnt[d]++;
            fl_left[d] = (c_fd[d] == 2) ? 1 : 0;
        end
        if ((stall || hold) && scnt[d] < c_max[d]) scnt[d]++;
        e.ctl = {stall || hold, stall || hold, stall || bub, hold, fl};
        sb[d].push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit mem, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2, input bit md, input bit pc);
        @(posedge clk);
        #1;
        rst_n = rst;
        ifa.mem_read_ex = mem; ifa.rd_ex = rd; ifa.rs1_id = rs1; ifa.rs2_id = rs2;
        ifa.rs1_used_id = u1; ifa.rs2_used_id = u2; ifa.muldiv_start_ex = md; ifa.pc_src = pc;
        ifb.mem_read_ex = mem; ifb.rd_ex = rd; ifb.rs1_id = rs1; ifb.rs2_id = rs2;
        ifb.rs1_used_id = u1; ifb.rs2_used_id = u2; ifb.muldiv_start_ex = md; ifb.pc_src = pc;
        model_step(0, rst, mem, rd, rs1, rs2, u1, u2, md, pc);
        model_step(1, rst, mem, rd, rs1, rs2, u1, u2, md, pc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the units present controls; pop and compare.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (sb[d].size() > 0) begin
                    e = sb[d].pop_front();
                    if (d == 0) begin
                        a.ctl = {ifa.pc_stall, ifa.if_id_stall, ifa.id_ex_bubble, ifa.ex_hold, ifa.if_id_flush};
                        a.sc  = 32'(ifa.stall_cnt);
                        a.fc  = 32'(ifa.flush_cnt);
                    end else begin
                        a.ctl = {ifb.pc_stall, ifb.if_id_stall, ifb.id_ex_bubble, ifb.ex_hold, ifb.if_id_flush};
                        a.sc  = ifb.stall_cnt;
                        a.fc  = ifb.flush_cnt;
                    end
                    compared++;
                    if (a != e) begin
                        mismatched++;
                        $display("FAIL dut%0d cycle %0d: ctl got %b want %b, stall_cnt got %0d want %0d, flush_cnt got %0d want %0d",
                                 d, cyc, a.ctl, e.ctl, a.sc, e.sc, a.fc, e.fc);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic with occasional resets.
    initial begin
        ifa.mem_read_ex = 0; ifa.rd_ex = 0; ifa.rs1_id = 0; ifa.rs2_id = 0;
        ifa.rs1_used_id = 0; ifa.rs2_used_id = 0; ifa.muldiv_start_ex = 0; ifa.pc_src = 0;
        ifb.mem_read_ex = 0; ifb.rd_ex = 0; ifb.rs1_id = 0; ifb.rs2_id = 0;
        ifb.rs1_used_id = 0; ifb.rs2_used_id = 0; ifb.muldiv_start_ex = 0; ifb.pc_src = 0;

        repeat (3) cycle(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        idle(2);
        // Single load-use match.
        cycle(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        idle(4);
        // Load into x0 never stalls.
        cycle(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        idle(2);
        // Mul/div hold, with a redirect arriving during the hold.
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        cycle(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        idle(4);
        // Redirect together with a load-use match.
        cycle(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1);
        idle(3);
        // Reset in the second stall cycle, then quiet release.
        cycle(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        cycle(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        idle(4);
        // Back-to-back load-use stalls drive the 4-bit counter to saturation.
        repeat (60) cycle(1, 1, 5'd7, 5'd3, 5'd7, 0, 1, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(1);
        repeat (2) @(posedge clk);

        for (int d = 0; d < 2; d++) begin
            compared++;
            if (sb[d].size() != 0) begin
                mismatched++;
                $display("FAIL dut%0d drain: %0d expectations left, want 0", d, sb[d].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
